// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP issue-unit constants, result record and operand sanitiser
package fpu_pkg;
    localparam logic [7:0] EXP_ZERO = 8'h00;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int RES_TAG_W = 5;

    typedef struct packed {
        logic [31:0] y;
        logic ovf;
        logic [RES_TAG_W-1:0] tag;
    } fadd_result_t;

    // Denormals flush to signed zero, NaN/inf collapse to signed inf
    function automatic logic [31:0] sanitize_fp(input logic [31:0] x);
        return x[30:23] == EXP_ZERO ? {x[31], 31'b0} :
               x[30:23] == EXP_MAX ? {x[31], EXP_MAX, 23'b0} : x;
    endfunction
endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: first-word-fall-through result buffer with occupancy count
module fpu_result_fifo #(
    parameter int W = 38,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic [W-1:0] din,
    input logic pop,
    output logic [W-1:0] dout,
    output logic [AW:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic full, do_push, do_pop;

    assign full = count == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop = pop && count != 0;
    assign dout = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    // Upstream credit accounting must make this unreachable
    assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/fadd_issue_unit.sv
// fadd_issue_unit: sanitises and issues fadd/fsub to a fixed-latency core, tracks tags, buffers results under credit
module fadd_issue_unit
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int TAG_W = 5,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst,
    input logic in_valid,
    output logic in_ready,
    input logic in_op,
    input logic [31:0] in_rs1,
    input logic [31:0] in_rs2,
    input logic [TAG_W-1:0] in_tag,
    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    input logic [31:0] fa_y,
    input logic fa_ovf,
    output logic out_valid,
    input logic out_ready,
    output logic [31:0] out_y,
    output logic out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(NSTAGE + 2);
    localparam int RW = 33 + TAG_W;

    logic [NSTAGE:0] vpipe;
    logic [TAG_W-1:0] tpipe [NSTAGE+1];
    logic [IW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [RW-1:0] head;
    logic accept, push;

    assign accept = in_valid && in_ready;
    assign push = vpipe[NSTAGE];
    // Credit covers every accepted request until it lands in the FIFO
    assign in_ready = (32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
    assign busy = inflight != 0 || fifo_count != 0;
    assign out_valid = fifo_count != 0;
    assign {out_y, out_ovf, out_tag} = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            fa_x1 <= '0;
            fa_x2 <= '0;
            vpipe <= '0;
            inflight <= '0;
        end else begin
            vpipe <= {vpipe[NSTAGE-1:0], accept};
            inflight <= inflight + IW'(accept) - IW'(push);
            if (accept) begin
                fa_x1 <= sanitize_fp(in_rs1);
                fa_x2 <= sanitize_fp(in_rs2) ^ {in_op, 31'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        tpipe[0] <= in_tag;
        for (int i = 1; i <= NSTAGE; i++) tpipe[i] <= tpipe[i-1];
    end

    fpu_result_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din({fa_y, fa_ovf, tpipe[NSTAGE]}),
        .pop(out_ready),
        .dout(head),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_fadd_issue_unit.sv
// tb_fadd_issue_unit: behavioural fadd core plus vector table and scoreboard checks
module tb_fadd_issue_unit;
    localparam int NSTAGE = 4;
    localparam int TAG_W = 5;
    localparam int FIFO_DEPTH = 8;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_op = 0;
    logic [31:0] in_rs1 = 0, in_rs2 = 0;
    logic [TAG_W-1:0] in_tag = 0;
    logic [31:0] fa_x1, fa_x2, fa_y;
    logic fa_ovf, out_valid, out_ready = 0, out_ovf, busy;
    logic [31:0] out_y;
    logic [TAG_W-1:0] out_tag;

    int tests = 0, fails = 0, nacc = 0, npop = 0;

    typedef struct {
        logic [31:0] y;
        logic ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic op;
        logic [31:0] rs1, rs2;
        logic [TAG_W-1:0] tag;
        logic [31:0] x1, x2, y;
        logic ovf;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    fadd_issue_unit #(.NSTAGE(NSTAGE), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .fa_x1(fa_x1), .fa_x2(fa_x2),
        .fa_y(fa_y), .fa_ovf(fa_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag), .busy(busy)
    );

    function automatic real f2r(input logic [31:0] x);
        real v;
        if (x[30:23] == 8'h00) return 0.0;
        if (x[30:23] == 8'hFF) v = 1.0e300;
        else v = real'({1'b1, x[22:0]}) * $pow(2.0, real'(int'(x[30:23]) - 150));
        return x[31] ? -v : v;
    endfunction

    // Round a double to single, flushing underflow and saturating overflow to inf
    function automatic logic [32:0] r2f(input real r);
        logic [63:0] b;
        logic [24:0] m;
        logic [28:0] rem;
        int ex;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {1'b0, b[63], 31'b0};
        ex = int'(b[62:52]) - 896;
        if (ex >= 255) return {1'b1, b[63], 8'hFF, 23'b0};
        if (ex <= 0) return {1'b0, b[63], 31'b0};
        m = {2'b01, b[51:29]};
        rem = b[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            ex++;
        end
        if (ex >= 255) return {1'b1, b[63], 8'hFF, 23'b0};
        return {1'b0, b[63], ex[7:0], m[22:0]};
    endfunction

    function automatic logic [32:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] san(input logic [31:0] x);
        if (x[30:23] == 8'h00) return {x[31], 31'b0};
        if (x[30:23] == 8'hFF) return {x[31], 8'hFF, 23'b0};
        return x;
    endfunction

    logic [32:0] core [NSTAGE];
    always @(posedge clk) begin
        core[0] <= fadd_model(fa_x1, fa_x2);
        for (int i = 1; i < NSTAGE; i++) core[i] <= core[i-1];
    end
    assign fa_y = core[NSTAGE-1][31:0];
    assign fa_ovf = core[NSTAGE-1][32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshakes complete at the following posedge; inputs only change just after posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_t e;
                logic [32:0] r;
                r = fadd_model(san(in_rs1), san(in_rs2) ^ {in_op, 31'b0});
                e.y = r[31:0];
                e.ovf = r[32];
                e.tag = in_tag;
                sb.push_back(e);
                nacc++;
            end
            if (out_valid && out_ready) begin
                npop++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got tag %0d expected no result", out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_y", 64'(out_y), 64'(e.y));
                    check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        in_valid = 1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = t;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) check("send_timeout", 64'(in_ready), 64'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, seen, a0, p0, sent, cyc;
        logic nw;
        vt[0] = '{1'b0, 32'h3F800000, 32'h40000000, 5'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
        vt[1] = '{1'b1, 32'h40400000, 32'h3F800000, 5'd6, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0};
        vt[2] = '{1'b0, 32'h00000001, 32'h3F800000, 5'd7, 32'h00000000, 32'h3F800000, 32'h3F800000, 1'b0};
        vt[3] = '{1'b0, 32'h7FC00000, 32'h3F800000, 5'd8, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1};
        vt[4] = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd9, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        vt[5] = '{1'b1, 32'h3F800000, 32'h80000005, 5'd31, 32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0};
        vt[6] = '{1'b0, 32'h40000000, 32'hFF812345, 5'd0, 32'h40000000, 32'hFF800000, 32'hFF800000, 1'b1};

        repeat (3) tick();
        rst = 0;
        check("rst_fa_x1", 64'(fa_x1), 64'd0);
        check("rst_fa_x2", 64'(fa_x2), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);

        out_ready = 1;
        for (int v = 0; v < 7; v++) begin
            send(vt[v].op, vt[v].rs1, vt[v].rs2, vt[v].tag);
            in_valid = 0;
            check("vec_fa_x1", 64'(fa_x1), 64'(vt[v].x1));
            check("vec_fa_x2", 64'(fa_x2), 64'(vt[v].x2));
            lat = 0;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("vec_latency", 64'(lat), 64'(NSTAGE + 1));
            check("vec_out_y", 64'(out_y), 64'(vt[v].y));
            check("vec_out_ovf", 64'(out_ovf), 64'(vt[v].ovf));
            check("vec_out_tag", 64'(out_tag), 64'(vt[v].tag));
            tick();
            check("vec_single_pulse", 64'(out_valid), 64'd0);
        end

        out_ready = 0;
        a0 = nacc;
        p0 = npop;
        for (int t = 0; t < 8; t++) begin
            check("bp_in_ready", 64'(in_ready), 64'd1);
            send(1'b0, 32'h3F800000 + (t << 18), 32'h40000000, TAG_W'(t));
        end
        in_tag = 5'd8;
        repeat (10) tick();
        check("bp_stall_ready", 64'(in_ready), 64'd0);
        check("bp_accepted", 64'(nacc - a0), 64'd8);
        check("bp_head_valid", 64'(out_valid), 64'd1);
        check("bp_head_tag", 64'(out_tag), 64'd0);
        out_ready = 1;
        for (int t = 8; t < 16; t++) send(1'b1, $urandom, $urandom, TAG_W'(t));
        in_valid = 0;
        drain();
        check("bp_results", 64'(npop - p0), 64'd16);

        for (int t = 20; t < 23; t++) send(1'b0, 32'h3F800000, 32'h3F800000, TAG_W'(t));
        in_valid = 0;
        tick();
        tick();
        rst = 1;
        sb.delete();
        tick();
        rst = 0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_ghost", 64'(seen), 64'd0);

        sent = 0;
        cyc = 0;
        nw = 1;
        p0 = npop;
        while (sent < 10000 && cyc < 60000) begin
            if (nw) begin
                in_valid = 1;
                in_op = 1'($urandom);
                in_rs1 = $urandom;
                in_rs2 = $urandom;
                in_tag = TAG_W'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            nw = in_ready;
            tick();
            cyc++;
            if (nw) sent++;
        end
        check("stream_sent", 64'(sent), 64'd10000);
        in_valid = 0;
        out_ready = 1;
        drain();
        check("stream_results", 64'(npop - p0), 64'd10000);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
